// File: rtl/calcn_dispatch_if.sv
// ---------------------------------------------------------------------------
// calcn_dispatch_if
//   Bundles the requester ports, the adder and shifter issue channels and the
//   per-port invalid-operation report of calcn_dispatch.
//
//   Requester side : req_cmd/req_d1/req_d2/req_r1 (4 bits per port),
//                    req_tag (TW per port), req_data (DW per port),
//                    req_ready (1 per port, high when that port's queue has room)
//   Adder channel  : add_vld/add_rdy plus add_port, add_cmd, add_d1, add_d2,
//                    add_r1, add_tag
//   Shifter channel: shift_vld/shift_rdy plus the same fields and shift_data
//   Invalid report : inv_vld (1 per port), inv_tag (TW per port)
//
//   Handshake: a transfer happens on a rising edge where vld and rdy are both
//   1. Once vld is raised it stays high, with every field of the channel
//   unchanged, until that transfer happens. rdy may change freely and never
//   depends combinationally on vld. A request port accepts on an edge where
//   its cmd is non-zero and its req_ready bit is 1.
//
//   Modports: slave = the dispatcher, master = requesters and execution units.
// ---------------------------------------------------------------------------
interface calcn_dispatch_if #(
    parameter int NPORTS = 4,
    parameter int DW     = 32,
    parameter int TW     = 2
);
    localparam int PW = $clog2(NPORTS);

    logic [NPORTS*4-1:0]  req_cmd;
    logic [NPORTS*4-1:0]  req_d1;
    logic [NPORTS*4-1:0]  req_d2;
    logic [NPORTS*4-1:0]  req_r1;
    logic [NPORTS*TW-1:0] req_tag;
    logic [NPORTS*DW-1:0] req_data;
    logic [NPORTS-1:0]    req_ready;

    logic                 add_vld;
    logic                 add_rdy;
    logic [PW-1:0]        add_port;
    logic [3:0]           add_cmd;
    logic [3:0]           add_d1;
    logic [3:0]           add_d2;
    logic [3:0]           add_r1;
    logic [TW-1:0]        add_tag;

    logic                 shift_vld;
    logic                 shift_rdy;
    logic [PW-1:0]        shift_port;
    logic [3:0]           shift_cmd;
    logic [3:0]           shift_d1;
    logic [3:0]           shift_d2;
    logic [3:0]           shift_r1;
    logic [TW-1:0]        shift_tag;
    logic [DW-1:0]        shift_data;

    logic [NPORTS-1:0]    inv_vld;
    logic [NPORTS*TW-1:0] inv_tag;

    modport slave (
        input  req_cmd, req_d1, req_d2, req_r1, req_tag, req_data,
        output req_ready,
        output add_vld, add_port, add_cmd, add_d1, add_d2, add_r1, add_tag,
        input  add_rdy,
        output shift_vld, shift_port, shift_cmd, shift_d1, shift_d2, shift_r1,
        output shift_tag, shift_data,
        input  shift_rdy,
        output inv_vld, inv_tag
    );

    modport master (
        output req_cmd, req_d1, req_d2, req_r1, req_tag, req_data,
        input  req_ready,
        input  add_vld, add_port, add_cmd, add_d1, add_d2, add_r1, add_tag,
        output add_rdy,
        input  shift_vld, shift_port, shift_cmd, shift_d1, shift_d2, shift_r1,
        input  shift_tag, shift_data,
        output shift_rdy,
        input  inv_vld, inv_tag
    );
endinterface

// File: rtl/calcn_dispatch.sv
// ---------------------------------------------------------------------------
// calcn_dispatch
//   Per-port in-order request queues feeding two execution channels (adder and
//   shifter), each with its own round-robin arbiter and registered issue
//   stage. Invalid commands are dropped and reported for one cycle.
//
//   Ports:
//     c_clk  - clock, all state changes on the rising edge
//     reset  - asynchronous, active-low
//     bus    - calcn_dispatch_if.slave (requests, issue channels, inv report)
//
//   Timing: a request accepted on edge 1 sits at the queue head in cycle 1,
//   is granted and loaded into the issue register on edge 2, so vld is seen
//   in cycle 2. The queues have no bypass and a full queue stays not-ready
//   even while its head is leaving.
// ---------------------------------------------------------------------------
module calcn_dispatch #(
    parameter int NPORTS = 4,
    parameter int DEPTH  = 2,
    parameter int DW     = 32,
    parameter int TW     = 2
) (
    input  logic            c_clk,
    input  logic            reset,
    calcn_dispatch_if.slave bus
);
    localparam int PW = $clog2(NPORTS);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(NPORTS - 1);

    typedef struct packed {
        logic [3:0]    cmd;
        logic [3:0]    d1;
        logic [3:0]    d2;
        logic [3:0]    r1;
        logic [TW-1:0] tag;
        logic [DW-1:0] data;
    } entry_t;

    function automatic logic is_add(input logic [3:0] c);
        return (c == 4'd1) || (c == 4'd2) || (c == 4'd12) || (c == 4'd13);
    endfunction

    function automatic logic is_shift(input logic [3:0] c);
        return (c == 4'd5) || (c == 4'd6) || (c == 4'd9) || (c == 4'd10);
    endfunction

    // Round-robin pick: first candidate at or after ptr. Returns {found, idx}.
    function automatic logic [PW:0] rr_pick(input logic [NPORTS-1:0] cand,
                                            input logic [PW-1:0]     ptr);
        logic          found;
        logic [PW-1:0] idx;
        logic [PW-1:0] k;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NPORTS; i++) begin
            k = PW'((int'(ptr) + i) % NPORTS);
            if (!found && cand[k]) begin
                found = 1'b1;
                idx   = k;
            end
        end
        return {found, idx};
    endfunction

    // Queue storage and occupancy
    entry_t        mem    [NPORTS][DEPTH];
    logic [AW-1:0] wr_ptr [NPORTS];
    logic [AW-1:0] rd_ptr [NPORTS];
    logic [CW-1:0] count  [NPORTS];

    entry_t            in_ent [NPORTS];
    entry_t            head   [NPORTS];
    logic [NPORTS-1:0] ready;
    logic [NPORTS-1:0] enq;
    logic [NPORTS-1:0] deq;
    logic [NPORTS-1:0] inv_set;
    logic [NPORTS-1:0] add_cand;
    logic [NPORTS-1:0] sh_cand;

    // Arbitration
    logic [PW-1:0] add_ptr, sh_ptr;
    logic [PW-1:0] add_gnt, sh_gnt;
    logic          add_gnt_vld, sh_gnt_vld;
    logic          add_fire, sh_fire;

    // Issue registers
    logic          add_vld_q, sh_vld_q;
    logic [PW-1:0] add_port_q, sh_port_q;
    logic [3:0]    add_cmd_q, add_d1_q, add_d2_q, add_r1_q;
    logic [3:0]    sh_cmd_q, sh_d1_q, sh_d2_q, sh_r1_q;
    logic [TW-1:0] add_tag_q, sh_tag_q;
    logic [DW-1:0] sh_data_q;

    logic [NPORTS-1:0]    inv_vld_q;
    logic [NPORTS*TW-1:0] inv_tag_q;

    always_comb begin
        for (int p = 0; p < NPORTS; p++) begin
            in_ent[p].cmd  = bus.req_cmd[4*p +: 4];
            in_ent[p].d1   = bus.req_d1[4*p +: 4];
            in_ent[p].d2   = bus.req_d2[4*p +: 4];
            in_ent[p].r1   = bus.req_r1[4*p +: 4];
            in_ent[p].tag  = bus.req_tag[TW*p +: TW];
            in_ent[p].data = bus.req_data[DW*p +: DW];

            ready[p]   = (count[p] != FULL);
            enq[p]     = ready[p] && (is_add(in_ent[p].cmd) || is_shift(in_ent[p].cmd));
            // cmd 0 is idle; anything else outside the two classes is reported
            inv_set[p] = ready[p] && (in_ent[p].cmd != 4'd0) &&
                         !(is_add(in_ent[p].cmd) || is_shift(in_ent[p].cmd));

            head[p]     = mem[p][rd_ptr[p]];
            add_cand[p] = (count[p] != '0) && is_add(head[p].cmd);
            sh_cand[p]  = (count[p] != '0) && is_shift(head[p].cmd);
        end
    end

    always_comb begin
        {add_gnt_vld, add_gnt} = rr_pick(add_cand, add_ptr);
        {sh_gnt_vld, sh_gnt}   = rr_pick(sh_cand, sh_ptr);
        // An issue register takes a new head when empty or draining this edge
        add_fire = add_gnt_vld && (!add_vld_q || bus.add_rdy);
        sh_fire  = sh_gnt_vld && (!sh_vld_q || bus.shift_rdy);
        // A head is either adder- or shifter-class, so the two grants can
        // never name the same port.
        for (int p = 0; p < NPORTS; p++) begin
            deq[p] = (add_fire && (add_gnt == PW'(p))) || (sh_fire && (sh_gnt == PW'(p)));
        end
    end

    // Queue pointers and occupancy
    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            for (int p = 0; p < NPORTS; p++) begin
                wr_ptr[p] <= '0;
                rd_ptr[p] <= '0;
                count[p]  <= '0;
            end
        end else begin
            for (int p = 0; p < NPORTS; p++) begin
                if (enq[p]) wr_ptr[p] <= wr_ptr[p] + AW'(1);
                if (deq[p]) rd_ptr[p] <= rd_ptr[p] + AW'(1);
                count[p] <= count[p] + CW'(enq[p]) - CW'(deq[p]);
            end
        end
    end

    // Queue payload needs no reset; only occupancy decides what is valid
    always_ff @(posedge c_clk) begin
        for (int p = 0; p < NPORTS; p++) begin
            if (enq[p]) mem[p][wr_ptr[p]] <= in_ent[p];
        end
    end

    // Invalid-operation report, one cycle per rejected command
    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            inv_vld_q <= '0;
            inv_tag_q <= '0;
        end else begin
            inv_vld_q <= inv_set;
            for (int p = 0; p < NPORTS; p++) begin
                inv_tag_q[TW*p +: TW] <= inv_set[p] ? in_ent[p].tag : '0;
            end
        end
    end

    // Adder issue register and pointer
    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            add_ptr    <= '0;
            add_vld_q  <= 1'b0;
            add_port_q <= '0;
            add_cmd_q  <= '0;
            add_d1_q   <= '0;
            add_d2_q   <= '0;
            add_r1_q   <= '0;
            add_tag_q  <= '0;
        end else begin
            if (!add_vld_q || bus.add_rdy) add_vld_q <= add_gnt_vld;
            if (add_fire) begin
                add_ptr    <= (add_gnt == LAST) ? '0 : add_gnt + PW'(1);
                add_port_q <= add_gnt;
                add_cmd_q  <= head[add_gnt].cmd;
                add_d1_q   <= head[add_gnt].d1;
                add_d2_q   <= head[add_gnt].d2;
                add_r1_q   <= head[add_gnt].r1;
                add_tag_q  <= head[add_gnt].tag;
            end
        end
    end

    // Shifter issue register and pointer
    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            sh_ptr    <= '0;
            sh_vld_q  <= 1'b0;
            sh_port_q <= '0;
            sh_cmd_q  <= '0;
            sh_d1_q   <= '0;
            sh_d2_q   <= '0;
            sh_r1_q   <= '0;
            sh_tag_q  <= '0;
            sh_data_q <= '0;
        end else begin
            if (!sh_vld_q || bus.shift_rdy) sh_vld_q <= sh_gnt_vld;
            if (sh_fire) begin
                sh_ptr    <= (sh_gnt == LAST) ? '0 : sh_gnt + PW'(1);
                sh_port_q <= sh_gnt;
                sh_cmd_q  <= head[sh_gnt].cmd;
                sh_d1_q   <= head[sh_gnt].d1;
                sh_d2_q   <= head[sh_gnt].d2;
                sh_r1_q   <= head[sh_gnt].r1;
                sh_tag_q  <= head[sh_gnt].tag;
                sh_data_q <= head[sh_gnt].data;
            end
        end
    end

    assign bus.req_ready  = ready;
    assign bus.add_vld    = add_vld_q;
    assign bus.add_port   = add_port_q;
    assign bus.add_cmd    = add_cmd_q;
    assign bus.add_d1     = add_d1_q;
    assign bus.add_d2     = add_d2_q;
    assign bus.add_r1     = add_r1_q;
    assign bus.add_tag    = add_tag_q;
    assign bus.shift_vld  = sh_vld_q;
    assign bus.shift_port = sh_port_q;
    assign bus.shift_cmd  = sh_cmd_q;
    assign bus.shift_d1   = sh_d1_q;
    assign bus.shift_d2   = sh_d2_q;
    assign bus.shift_r1   = sh_r1_q;
    assign bus.shift_tag  = sh_tag_q;
    assign bus.shift_data = sh_data_q;
    assign bus.inv_vld    = inv_vld_q;
    assign bus.inv_tag    = inv_tag_q;
endmodule

// File: tb/tb_calcn_dispatch.sv
// ---------------------------------------------------------------------------
// tb_calcn_dispatch
//   Self-checking bench for calcn_dispatch (NPORTS=4, DEPTH=2, DW=32, TW=2).
//   Inputs change 1 time unit after the rising edge; a monitor samples the
//   issue channels on the falling edge, pops the expected queue on every
//   vld&rdy transfer and checks that held channels stay stable.
// ---------------------------------------------------------------------------
module tb_calcn_dispatch;
    localparam int NPORTS = 4;
    localparam int DEPTH  = 2;
    localparam int DW     = 32;
    localparam int TW     = 2;
    localparam int PW     = 2;

    logic c_clk = 1'b0;
    logic reset = 1'b0;

    always #5 c_clk = ~c_clk;

    calcn_dispatch_if #(.NPORTS(NPORTS), .DW(DW), .TW(TW)) bus ();

    calcn_dispatch #(.NPORTS(NPORTS), .DEPTH(DEPTH), .DW(DW), .TW(TW)) dut (
        .c_clk (c_clk),
        .reset (reset),
        .bus   (bus)
    );

    int          checks   = 0;
    int          failures = 0;
    logic [63:0] exp_add_q[$];
    logic [63:0] exp_sh_q[$];
    bit          rand_rdy = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pack_op(input logic [PW-1:0] port, input logic [3:0] cmd,
                                            input logic [3:0] d1, input logic [3:0] d2,
                                            input logic [3:0] r1, input logic [TW-1:0] tag,
                                            input logic [DW-1:0] data);
        return {12'd0, port, cmd, d1, d2, r1, tag, data};
    endfunction

    // ---------------- clock/reset and driver tasks ----------------
    task automatic tick();
        @(posedge c_clk);
        #1;
        if (rand_rdy) begin
            bus.add_rdy   = 1'($urandom_range(0, 1));
            bus.shift_rdy = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic drive_req(input int p, input logic [3:0] cmd, input logic [3:0] d1,
                             input logic [3:0] d2, input logic [3:0] r1,
                             input logic [TW-1:0] tag, input logic [DW-1:0] data);
        bus.req_cmd[4*p +: 4]    = cmd;
        bus.req_d1[4*p +: 4]     = d1;
        bus.req_d2[4*p +: 4]     = d2;
        bus.req_r1[4*p +: 4]     = r1;
        bus.req_tag[TW*p +: TW]  = tag;
        bus.req_data[DW*p +: DW] = data;
    endtask

    task automatic clear_req(input int p);
        drive_req(p, 4'd0, 4'd0, 4'd0, 4'd0, '0, '0);
    endtask

    // Drive a request and record the expected issue for its class
    task automatic issue_req(input int p, input logic [3:0] cmd, input logic [3:0] d1,
                             input logic [3:0] d2, input logic [3:0] r1,
                             input logic [TW-1:0] tag, input logic [DW-1:0] data);
        drive_req(p, cmd, d1, d2, r1, tag, data);
        if (cmd inside {4'd1, 4'd2, 4'd12, 4'd13})
            exp_add_q.push_back(pack_op(PW'(p), cmd, d1, d2, r1, tag, '0));
        else if (cmd inside {4'd5, 4'd6, 4'd9, 4'd10})
            exp_sh_q.push_back(pack_op(PW'(p), cmd, d1, d2, r1, tag, data));
    endtask

    // Hold the driven request on port p until an edge accepts it
    task automatic wait_accept(input int p);
        logic r;
        for (int n = 0; n < 100; n++) begin
            r = bus.req_ready[p];
            tick();
            if (r) begin
                clear_req(p);
                return;
            end
        end
        check("accept_timeout", 64'(bus.req_ready[p]), 64'(1));
        clear_req(p);
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 100 && (exp_add_q.size() + exp_sh_q.size()) != 0; n++) tick();
        check("drain", 64'(exp_add_q.size() + exp_sh_q.size()), 64'(0));
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        exp_add_q.delete();
        exp_sh_q.delete();
        for (int p = 0; p < NPORTS; p++) clear_req(p);
        #1;
        check("rst_ready", 64'(bus.req_ready), 64'(4'hF));
        check("rst_add_vld", 64'(bus.add_vld), 64'(0));
        check("rst_shift_vld", 64'(bus.shift_vld), 64'(0));
        check("rst_inv_vld", 64'(bus.inv_vld), 64'(0));
        check("rst_inv_tag", 64'(bus.inv_tag), 64'(0));
        check("rst_add_fields", pack_op(bus.add_port, bus.add_cmd, bus.add_d1, bus.add_d2,
                                        bus.add_r1, bus.add_tag, '0), 64'(0));
        check("rst_shift_fields", pack_op(bus.shift_port, bus.shift_cmd, bus.shift_d1,
                                          bus.shift_d2, bus.shift_r1, bus.shift_tag,
                                          bus.shift_data), 64'(0));
        repeat (2) tick();
        reset = 1'b1;
        check("ready_after_rst", 64'(bus.req_ready), 64'(4'hF));
    endtask

    // ---------------- scoreboard monitor ----------------
    logic [63:0] prev_a, prev_s;
    bit          add_hold = 1'b0;
    bit          sh_hold  = 1'b0;

    always @(negedge c_clk) begin
        logic [63:0] cur_a, cur_s;
        cur_a = pack_op(bus.add_port, bus.add_cmd, bus.add_d1, bus.add_d2, bus.add_r1,
                        bus.add_tag, '0);
        cur_s = pack_op(bus.shift_port, bus.shift_cmd, bus.shift_d1, bus.shift_d2,
                        bus.shift_r1, bus.shift_tag, bus.shift_data);
        if (!reset) begin
            add_hold = 1'b0;
            sh_hold  = 1'b0;
        end else begin
            if (add_hold) begin
                check("add_hold_vld", 64'(bus.add_vld), 64'(1));
                check("add_hold", cur_a, prev_a);
            end
            if (bus.add_vld && bus.add_rdy) begin
                if (exp_add_q.size() == 0) check("add_unexpected", 64'(bus.add_vld), 64'(0));
                else check("add_issue", cur_a, exp_add_q.pop_front());
            end
            add_hold = bus.add_vld && !bus.add_rdy;
            prev_a   = cur_a;

            if (sh_hold) begin
                check("shift_hold_vld", 64'(bus.shift_vld), 64'(1));
                check("shift_hold", cur_s, prev_s);
            end
            if (bus.shift_vld && bus.shift_rdy) begin
                if (exp_sh_q.size() == 0) check("shift_unexpected", 64'(bus.shift_vld), 64'(0));
                else check("shift_issue", cur_s, exp_sh_q.pop_front());
            end
            sh_hold = bus.shift_vld && !bus.shift_rdy;
            prev_s  = cur_s;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    // ---------------- scenarios ----------------
    logic [3:0] sh_tab [4];
    logic [3:0] add_tab [4];

    initial begin
        int p;
        sh_tab  = '{4'd5, 4'd6, 4'd9, 4'd10};
        add_tab = '{4'd1, 4'd2, 4'd12, 4'd13};
        bus.add_rdy   = 1'b1;
        bus.shift_rdy = 1'b1;
        for (int i = 0; i < NPORTS; i++) clear_req(i);

        // Single add: two-cycle latency, no bypass through an empty queue
        apply_reset();
        issue_req(0, 4'd1, 4'd3, 4'd4, 4'd5, 2'd2, 32'h0);
        tick();
        clear_req(0);
        check("single_cycle1_vld", 64'(bus.add_vld), 64'(0));
        tick();
        check("single_cycle2_vld", 64'(bus.add_vld), 64'(1));
        check("single_port", 64'(bus.add_port), 64'(0));
        check("single_tag", 64'(bus.add_tag), 64'(2));
        check("single_d1", 64'(bus.add_d1), 64'(3));
        check("single_d2", 64'(bus.add_d2), 64'(4));
        check("single_r1", 64'(bus.add_r1), 64'(5));
        wait_drain();

        // Round-robin: two batches of four, one grant per cycle in port order
        apply_reset();
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < NPORTS; i++)
                issue_req(i, 4'd2, 4'(i), 4'(b), 4'(i + 4), 2'(i), 32'h0);
            tick();
            for (int i = 0; i < NPORTS; i++) clear_req(i);
            repeat (5) tick();
            check("rr_batch_done", 64'(exp_add_q.size()), 64'(0));
        end

        // Dual issue on different ports in the same cycle
        apply_reset();
        issue_req(1, 4'd5, 4'd1, 4'd2, 4'd3, 2'd3, 32'hA5A5_0F0F);
        issue_req(2, 4'd1, 4'd6, 4'd7, 4'd8, 2'd1, 32'h0);
        tick();
        clear_req(1);
        clear_req(2);
        tick();
        check("dual_add_vld", 64'(bus.add_vld), 64'(1));
        check("dual_shift_vld", 64'(bus.shift_vld), 64'(1));
        check("dual_shift_port", 64'(bus.shift_port), 64'(1));
        check("dual_add_port", 64'(bus.add_port), 64'(2));
        wait_drain();

        // Back-pressure: queue fills behind a held issue register
        apply_reset();
        bus.add_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            issue_req(0, add_tab[i], 4'(i), 4'(i + 1), 4'(i + 2), 2'(i), 32'h0);
            wait_accept(0);
        end
        check("bp_ready_full", 64'(bus.req_ready[0]), 64'(0));
        check("bp_held_vld", 64'(bus.add_vld), 64'(1));
        check("bp_held_cmd", 64'(bus.add_cmd), 64'(1));
        issue_req(0, add_tab[3], 4'd9, 4'd10, 4'd11, 2'd3, 32'h0);
        repeat (3) begin
            check("bp_ready_hold", 64'(bus.req_ready[0]), 64'(0));
            tick();
        end
        bus.add_rdy = 1'b1;
        check("full_with_deq_ready", 64'(bus.req_ready[0]), 64'(0));
        wait_accept(0);
        wait_drain();

        // Invalid command: one-cycle report, nothing issued
        apply_reset();
        drive_req(3, 4'd7, 4'd1, 4'd1, 4'd1, 2'd1, 32'h0);
        tick();
        clear_req(3);
        check("inv_vld", 64'(bus.inv_vld), 64'(4'b1000));
        check("inv_tag3", 64'(bus.inv_tag[3*TW +: TW]), 64'(1));
        tick();
        check("inv_vld_clear", 64'(bus.inv_vld), 64'(0));
        check("inv_no_add", 64'(bus.add_vld), 64'(0));
        check("inv_no_shift", 64'(bus.shift_vld), 64'(0));
        tick();
        check("inv_no_add_later", 64'(bus.add_vld), 64'(0));

        // Random streams, one port per channel, with random back-pressure
        apply_reset();
        p = $urandom_range(0, NPORTS - 1);
        rand_rdy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            issue_req(p, add_tab[$urandom_range(0, 3)], 4'($urandom_range(0, 15)),
                      4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                      2'($urandom_range(0, 3)), 32'h0);
            wait_accept(p);
        end
        p = $urandom_range(0, NPORTS - 1);
        for (int i = 0; i < 12; i++) begin
            issue_req(p, sh_tab[$urandom_range(0, 3)], 4'($urandom_range(0, 15)),
                      4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                      2'($urandom_range(0, 3)), $urandom);
            wait_accept(p);
        end
        rand_rdy      = 1'b0;
        bus.add_rdy   = 1'b1;
        bus.shift_rdy = 1'b1;
        wait_drain();

        // Reset mid-operation: three queued entries plus a held issue
        apply_reset();
        bus.add_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_req(0, 4'd2, 4'(i), 4'd0, 4'd0, 2'(i), 32'h0);
            wait_accept(0);
        end
        drive_req(1, 4'd1, 4'd15, 4'd0, 4'd0, 2'd3, 32'h0);
        wait_accept(1);
        check("rstmid_pre_vld", 64'(bus.add_vld), 64'(1));
        #2;
        reset = 1'b0;
        #1;
        check("rstmid_add_vld", 64'(bus.add_vld), 64'(0));
        check("rstmid_shift_vld", 64'(bus.shift_vld), 64'(0));
        check("rstmid_ready", 64'(bus.req_ready), 64'(4'hF));
        check("rstmid_add_cmd", 64'(bus.add_cmd), 64'(0));
        bus.add_rdy = 1'b1;
        @(posedge c_clk);
        #1;
        reset = 1'b1;
        check("rstmid_ready_after", 64'(bus.req_ready), 64'(4'hF));
        repeat (10) tick();
        check("rstmid_no_add", 64'(bus.add_vld), 64'(0));
        check("rstmid_no_shift", 64'(bus.shift_vld), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/calcn_dispatch.md
CALCN_DISPATCH -- requirements
Module: calcn_dispatch

Interface
REQ-001 Parameter NPORTS, default 4: number of requester ports, 2..8.
REQ-002 Parameter DEPTH, default 2: per-port queue entries, power of 2, 2..16.
REQ-003 Parameter DW, default 32: request data width.
REQ-004 Parameter TW, default 2: tag width.
REQ-005 Port c_clk, in, 1: the only clock; all state updates on the rising edge.
REQ-006 Port reset, in, 1: asynchronous, active-low reset.
REQ-007 Ports req_cmd, req_d1, req_d2 and req_r1, in, NPORTS*4 each: per-port command and register fields; port p occupies bits [4p +: 4].
REQ-008 Ports req_tag, in, NPORTS*TW, and req_data, in, NPORTS*DW: per-port tag and data.
REQ-009 Port req_ready, out, NPORTS: bit p is 1 when port p's queue is not full.
REQ-010 Ports add_vld, out, 1, and add_rdy, in, 1: adder issue handshake.
REQ-011 Ports add_port, add_cmd, add_d1, add_d2, add_r1 and add_tag, out: the issued adder operation; widths are clog2(NPORTS), 4, 4, 4, 4 and TW.
REQ-012 Ports shift_vld, shift_rdy, shift_port, shift_cmd, shift_d1, shift_d2, shift_r1 and shift_tag, plus shift_data (out, DW): the shifter issue channel, mirroring the adder channel.
REQ-013 Ports inv_vld, out, NPORTS, and inv_tag, out, NPORTS*TW: per-port invalid-operation report.

Function
REQ-014 Command classes:
- adder: 1, 2, 12, 13
- shifter: 5, 6, 9, 10
- idle: 0
- invalid: all other values.
REQ-015 Acceptance: port p accepts a request on an edge where req_cmd[p] != 0 and req_ready[p] = 1.
REQ-016 Enqueue: an accepted adder-class or shifter-class request is written to port p's FIFO with cmd, d1, d2, r1, tag and data.
REQ-017 Invalid commands: an accepted invalid command is not queued; inv_vld[p] = 1 and inv_tag[p] = the request tag for exactly the next cycle.
REQ-018 Issue order: each port issues strictly in order; only the head entry of a port's queue is eligible.
REQ-019 Adder arbiter:
- candidates are ports whose head is adder-class;
- round-robin, starting from the pointer add_ptr;
- after a grant to port g, add_ptr = (g+1) mod NPORTS.
REQ-020 Shifter arbiter: identical to the adder arbiter, using an independent pointer sh_ptr.
REQ-021 Dual issue: the adder and shifter channels may both grant in the same cycle, to different ports.
REQ-022 Issue registers: the adder and shifter issue outputs are registered.
- An issue register loads a granted head when it is empty, or when it is being consumed that cycle (vld & rdy).
- The granted head is dequeued on that same edge.
REQ-023 Hold stability: while vld = 1 and rdy = 0, every field of that channel stays stable.
REQ-024 Latency: a request presented in cycle 0 to an idle block produces vld = 1 in cycle 2. Sustained throughput is 1 issue per channel per cycle.
REQ-025 Full queue: a full queue with a simultaneous dequeue still reports req_ready = 0 that cycle; no same-cycle pass-through.
REQ-026 Empty queue: a request into an empty queue is not issued in the same cycle; the queue has no bypass path.
REQ-027 Pointer wrap: the queue read and write pointers wrap modulo DEPTH. Occupancy is tracked with a count of width clog2(DEPTH)+1.
REQ-028 Shifter data: shift_data carries the queued req_data; it is meaningful for cmd 9 and is passed through for all other shifter commands.

Reset
REQ-029 While reset = 0, the following are cleared immediately and asynchronously:
- all queues emptied;
- add_ptr and sh_ptr set to 0;
- add_vld, shift_vld and inv_vld set to 0;
- all issue fields and inv_tag set to 0.
REQ-030 Ready after reset: req_ready is all-ones while in reset and on the first cycle after reset.
REQ-031 Reset mid-operation: any in-flight or queued operation is discarded with no report.

Verification
REQ-032 Single add: port 0, cmd=1, tag=2, d1=3, d2=4, r1=5, presented in cycle 0 -> cycle 2 shows add_vld=1, add_port=0, add_tag=2, add_d1=3, add_d2=4, add_r1=5.
REQ-033 Round-robin: all 4 ports present cmd=2 on the same cycle, add_rdy=1 -> grants in port order 0,1,2,3 on consecutive cycles; a repeat batch is granted 0,1,2,3 again.
REQ-034 Dual issue:
- stimulus: port 1 presents cmd=5 and port 2 presents cmd=1 together;
- required response: shift_vld and add_vld both 1 in the same cycle, shift_port=1, add_port=2.
REQ-035 Back-pressure, DEPTH=2:
- stimulus: add_rdy=0 while port 0 sends 4 add commands;
- required response: req_ready[0]=0 after the third accept (2 entries queued, 1 held in the issue register); add fields stable;
- then raise add_rdy: all 4 commands issue in order.
REQ-036 Invalid command: port 3, cmd=7, tag=1 -> inv_vld[3]=1 and inv_tag[3]=1 for one cycle; no issue on either channel.
REQ-037 Reset mid-operation:
- stimulus: assert reset while queues hold 3 entries and add_vld=1;
- required response: add_vld=0 immediately, req_ready all-ones, no issue after reset is released.
